// File: rtl/sound_pkg.sv
// sound_pkg: shared types and melody constants for the sound event scheduler
package sound_pkg;

    typedef enum logic [1:0] {
        EVT_LOSE   = 2'd0,
        EVT_WIN    = 2'd1,
        EVT_SPLASH = 2'd2,
        EVT_JUMP   = 2'd3
    } evt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef logic [9:0] freq_t;

    localparam int IDX_W = 2;

    localparam int LOSE_LEN   = 3;
    localparam int WIN_LEN    = 4;
    localparam int SPLASH_LEN = 2;
    localparam int JUMP_LEN   = 1;

    localparam freq_t LOSE_N0   = 10'd800;
    localparam freq_t LOSE_N1   = 10'd600;
    localparam freq_t LOSE_N2   = 10'd400;
    localparam freq_t WIN_N0    = 10'd300;
    localparam freq_t WIN_N1    = 10'd400;
    localparam freq_t WIN_N2    = 10'd500;
    localparam freq_t WIN_N3    = 10'd700;
    localparam freq_t SPLASH_N0 = 10'd900;
    localparam freq_t SPLASH_N1 = 10'd850;
    localparam freq_t JUMP_N0   = 10'd512;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sound_note_rom.sv
// sound_note_rom: combinational melody lookup of (event, note index) to {freq, last_note}
import sound_pkg::*;

module sound_note_rom (
    input  evt_t              evt,
    input  logic [IDX_W-1:0]  idx,
    output freq_t             freq,
    output logic              last
);

    logic [IDX_W-1:0] last_idx;

    // Select the note code and the index of the final note for the chosen melody
    always_comb begin
        freq     = '0;
        last_idx = '0;
        case (evt)
            EVT_LOSE: begin
                last_idx = IDX_W'(LOSE_LEN - 1);
                freq     = (idx == 2'd0) ? LOSE_N0 : (idx == 2'd1) ? LOSE_N1 : (idx == 2'd2) ? LOSE_N2 : '0;
            end
            EVT_WIN: begin
                last_idx = IDX_W'(WIN_LEN - 1);
                freq     = (idx == 2'd0) ? WIN_N0 : (idx == 2'd1) ? WIN_N1 : (idx == 2'd2) ? WIN_N2 : WIN_N3;
            end
            EVT_SPLASH: begin
                last_idx = IDX_W'(SPLASH_LEN - 1);
                freq     = (idx == 2'd0) ? SPLASH_N0 : (idx == 2'd1) ? SPLASH_N1 : '0;
            end
            default: begin
                last_idx = IDX_W'(JUMP_LEN - 1);
                freq     = (idx == 2'd0) ? JUMP_N0 : '0;
            end
        endcase
        last = (idx == last_idx);
    end

endmodule

// File: rtl/sound_event_scheduler.sv
// sound_event_scheduler: latches sound event requests and plays one melody at a time by priority (optional SOUND_MUTE_EN adds a mute input)
import sound_pkg::*;

module sound_event_scheduler #(
    parameter int NOTE_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 2_500_000
) (
    input  logic       clk,
    input  logic       resetN,
`ifdef SOUND_MUTE_EN
    input  logic       mute,
`endif
    input  logic       req_lose,
    input  logic       req_win,
    input  logic       req_splash,
    input  logic       req_jump,
    output logic [9:0] sound_freq,
    output logic       enable_sound,
    output logic       busy,
    output logic [1:0] active_evt,
    output logic       done
);

    localparam int TW = $clog2(max_int(NOTE_TICKS, GAP_TICKS) + 1);

    state_t           state;
    evt_t             active;
    evt_t             gnt;
    evt_t             rom_evt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] rom_idx;
    logic [TW-1:0]    timer;
    logic [3:0]       pending;
    logic [3:0]       req;
    logic [3:0]       drop;
    logic [3:0]       clr;
    logic             grant;
    logic             note_end;
    logic             gap_end;
    logic             m;
    freq_t            rom_freq;
    logic             rom_last;

`ifdef SOUND_MUTE_EN
    assign m = mute;
`else
    assign m = 1'b0;
`endif

    assign active_evt = active;
    assign req        = {req_jump, req_splash, req_win, req_lose};
    assign note_end   = (timer == TW'(NOTE_TICKS - 1));
    assign gap_end    = (timer == TW'(GAP_TICKS - 1));

    // Pick the highest-priority pending event and decide whether it starts now (idle) or preempts a strictly lower one
    always_comb begin
        gnt     = pending[0] ? EVT_LOSE : pending[1] ? EVT_WIN : pending[2] ? EVT_SPLASH : EVT_JUMP;
        grant   = (|pending) && (state == ST_IDLE || gnt < active);
        drop    = busy ? (4'b0001 << active) : 4'b0000;
        clr     = grant ? (4'b0001 << gnt) : 4'b0000;
        rom_evt = grant ? gnt : active;
        rom_idx = grant ? '0 : (state == ST_GAP) ? idx + 1'b1 : idx;
    end

    sound_note_rom u_rom (
        .evt  (rom_evt),
        .idx  (rom_idx),
        .freq (rom_freq),
        .last (rom_last)
    );

    // Sequencer: pending latch, note/gap timing, preemption and registered tone outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= ST_IDLE;
            active       <= EVT_LOSE;
            idx          <= '0;
            timer        <= '0;
            pending      <= '0;
            sound_freq   <= '0;
            enable_sound <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            pending <= (pending | (req & ~drop)) & ~clr;
            done    <= 1'b0;
            if (grant) begin
                state        <= ST_NOTE;
                active       <= gnt;
                idx          <= '0;
                timer        <= '0;
                busy         <= 1'b1;
                enable_sound <= !m;
                sound_freq   <= m ? '0 : rom_freq;
            end else begin
                case (state)
                    ST_NOTE: begin
                        if (note_end) begin
                            timer        <= '0;
                            enable_sound <= 1'b0;
                            sound_freq   <= '0;
                            if (rom_last) begin
                                state  <= ST_IDLE;
                                active <= EVT_LOSE;
                                idx    <= '0;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                            end else begin
                                state <= ST_GAP;
                            end
                        end else begin
                            timer        <= timer + 1'b1;
                            enable_sound <= !m;
                            sound_freq   <= m ? '0 : rom_freq;
                        end
                    end
                    ST_GAP: begin
                        if (gap_end) begin
                            state        <= ST_NOTE;
                            idx          <= idx + 1'b1;
                            timer        <= '0;
                            enable_sound <= !m;
                            sound_freq   <= m ? '0 : rom_freq;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sound_event_scheduler.sv
// tb_sound_event_scheduler: scoreboard bench comparing the per-cycle output trace against expected melodies
module tb_sound_event_scheduler;

    localparam int NT = 4;
    localparam int GT = 2;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       mute = 1'b0;
    logic       req_lose = 1'b0;
    logic       req_win = 1'b0;
    logic       req_splash = 1'b0;
    logic       req_jump = 1'b0;
    logic [9:0] sound_freq;
    logic       enable_sound;
    logic       busy;
    logic [1:0] active_evt;
    logic       done;

    int n_chk = 0;
    int n_fail = 0;
    logic [14:0] q[$];

    always #5 clk = ~clk;

    sound_event_scheduler #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
        .clk          (clk),
        .resetN       (resetN),
`ifdef SOUND_MUTE_EN
        .mute         (mute),
`endif
        .req_lose     (req_lose),
        .req_win      (req_win),
        .req_splash   (req_splash),
        .req_jump     (req_jump),
        .sound_freq   (sound_freq),
        .enable_sound (enable_sound),
        .busy         (busy),
        .active_evt   (active_evt),
        .done         (done)
    );

    function automatic logic [14:0] obs();
        return {sound_freq, enable_sound, busy, active_evt, done};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_idle(input int n);
        repeat (n) q.push_back(15'd0);
    endtask

    task automatic push_entry(input logic [9:0] f, input logic en, input logic b, input logic [1:0] e, input logic d);
        q.push_back({f, en, b, e, d});
    endtask

    task automatic push_melody(input logic [1:0] e, input int n, input logic [9:0] f0, input logic [9:0] f1, input logic [9:0] f2, input logic [9:0] f3);
        logic [9:0] f[4];
        f = '{f0, f1, f2, f3};
        for (int i = 0; i < n; i++) begin
            repeat (NT) push_entry(f[i], 1'b1, 1'b1, e, 1'b0);
            if (i < n - 1) repeat (GT) push_entry(10'd0, 1'b0, 1'b1, e, 1'b0);
        end
        push_entry(10'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() > 0) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    // Compare each sampled output word against the next expected scoreboard entry
    always @(negedge clk) begin
        if (q.size() > 0) check("trace", obs(), q.pop_front());
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs", obs(), 0);
        #1 resetN = 1'b1;
        push_idle(5);
        drain();

        req_jump = 1'b1;
        push_idle(1);
        push_melody(2'd3, 1, 10'd512, 10'd0, 10'd0, 10'd0);
        push_idle(2);
        @(negedge clk); #1 req_jump = 1'b0;
        drain();

        req_win = 1'b1;
        push_idle(1);
        push_melody(2'd1, 4, 10'd300, 10'd400, 10'd500, 10'd700);
        push_idle(2);
        @(negedge clk); #1 req_win = 1'b0;
        drain();

        req_jump = 1'b1;
        req_splash = 1'b1;
        push_idle(1);
        push_melody(2'd2, 2, 10'd900, 10'd850, 10'd0, 10'd0);
        push_melody(2'd3, 1, 10'd512, 10'd0, 10'd0, 10'd0);
        push_idle(2);
        @(negedge clk); #1 req_jump = 1'b0; req_splash = 1'b0;
        drain();

        req_win = 1'b1;
        push_idle(1);
        repeat (NT) push_entry(10'd300, 1'b1, 1'b1, 2'd1, 1'b0);
        repeat (GT) push_entry(10'd0, 1'b0, 1'b1, 2'd1, 1'b0);
        repeat (2) push_entry(10'd400, 1'b1, 1'b1, 2'd1, 1'b0);
        @(negedge clk); #1 req_win = 1'b0;
        drain();
        req_lose = 1'b1;
        push_entry(10'd400, 1'b1, 1'b1, 2'd1, 1'b0);
        push_melody(2'd0, 3, 10'd800, 10'd600, 10'd400, 10'd0);
        push_idle(3);
        @(negedge clk); #1 req_lose = 1'b0;
        drain();

        req_lose = 1'b1;
        push_idle(1);
        repeat (2) push_entry(10'd800, 1'b1, 1'b1, 2'd0, 1'b0);
        @(negedge clk); #1 req_lose = 1'b0;
        drain();
        req_jump = 1'b1;
        push_entry(10'd800, 1'b1, 1'b1, 2'd0, 1'b0);
        drain();
        req_jump = 1'b0;
        resetN = 1'b0;
        #1;
        check("async_reset", obs(), 0);
        repeat (2) @(negedge clk);
        #1 resetN = 1'b1;
        push_idle(6);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
